debug_ctrl: RTL and testbench

DEBUG_CTRL -- requirements
Module: debug_ctrl

---
 rtl/debug_ctrl.sv | 168 ++++++++++++++++
 tb/tb_debug_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ctrl.sv
// Single-step / run-mode clock controller for a CPU debug board: conditions the
// raw buttons and switch, then issues fixed-length cpu_clk pulses on request.
module debug_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_LEN       = 4,
    parameter int RUN_PERIOD      = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_sel,
    input  logic        sw_run,
    output logic        cpu_clk,
    output logic [3:0]  led_mux_sel,
    output logic [15:0] step_count,
    output logic        busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int RW = $clog2(RUN_PERIOD + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [RW-1:0] RUN_LAST   = RW'(RUN_PERIOD - 1);

    localparam int N_IN     = 3;
    localparam int IDX_STEP = 0;
    localparam int IDX_SEL  = 1;
    localparam int IDX_RUN  = 2;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } step_state_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync_q1;
    logic [N_IN-1:0] sync_q2;
    logic [N_IN-1:0] deb;
    logic [N_IN-1:0] deb_q;
    logic [DW-1:0]   db_cnt [N_IN];

    logic            step_rise;
    logic            sel_rise;
    logic            run_mode;
    logic            run_tick;
    logic            step_req;
    logic [RW-1:0]   run_cnt;

    step_state_t     state;
    step_state_t     next_state;
    logic [PW-1:0]   phase;
    logic            phase_done;
    logic            start;

    assign raw = {sw_run, btn_sel, btn_step};

    // Each input: two-flop synchronizer, then a stability counter that must see
    // DEBOUNCE_CYCLES consecutive disagreeing samples before the level flips.
    // NOTE: sequential state uses <= so every flop samples pre-edge values; a
    // blocking = here would let sync_q2 see this cycle's sync_q1 and collapse
    // the synchronizer to one stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            deb     <= '0;
            deb_q   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            deb_q   <= deb;
            for (int i = 0; i < N_IN; i++) begin
                if (sync_q2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign step_rise = deb[IDX_STEP] & ~deb_q[IDX_STEP];
    assign sel_rise  = deb[IDX_SEL]  & ~deb_q[IDX_SEL];
    assign run_mode  = deb[IDX_RUN];

    // Free-running period counter; held at zero outside run mode so every entry
    // into run mode waits a full period before the first automatic step.
    always_ff @(posedge clk) begin
        if (!rst || !run_mode) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_LAST) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + RW'(1);
        end
    end

    assign run_tick = run_mode && (run_cnt == RUN_LAST);
    assign step_req = run_mode ? run_tick : step_rise;

    assign phase_done = (phase == PHASE_LAST);

    // NOTE: next_state and start get defaults before the case, so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (step_req) begin
                    next_state = HIGH;
                    start      = 1'b1;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                if (phase_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they change on the same edge
    // as the state register; requests arriving outside IDLE simply vanish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            phase       <= '0;
            cpu_clk     <= 1'b0;
            busy        <= 1'b0;
            step_count  <= '0;
            led_mux_sel <= '0;
        end else begin
            state   <= next_state;
            cpu_clk <= (next_state == HIGH);
            busy    <= (next_state != IDLE);
            if (next_state != state || state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
            if (start) begin
                step_count <= step_count + 16'd1;
            end
            if (sel_rise) begin
                led_mux_sel <= led_mux_sel + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_debug_ctrl.sv
// Scoreboard bench for debug_ctrl: stimulus queues expected pulses and selector
// updates with their cycle numbers; a negedge monitor pops and compares them.
module tb_debug_ctrl;

    localparam int DB = 4;
    localparam int PL = 2;
    localparam int RP = 10;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        btn_step = 1'b0;
    logic        btn_sel  = 1'b0;
    logic        sw_run   = 1'b0;
    logic        cpu_clk;
    logic [3:0]  led_mux_sel;
    logic [15:0] step_count;
    logic        busy;

    // Second instance with long pulses so a press can debounce mid-HIGH.
    logic        b2_step = 1'b0;
    logic        b2_sel  = 1'b0;
    logic        b2_run  = 1'b0;
    logic        cpu_clk2;
    logic [3:0]  led2;
    logic [15:0] step_count2;
    logic        busy2;

    debug_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_LEN(PL), .RUN_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_sel(btn_sel), .sw_run(sw_run),
        .cpu_clk(cpu_clk), .led_mux_sel(led_mux_sel), .step_count(step_count), .busy(busy)
    );

    debug_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_LEN(8), .RUN_PERIOD(RP)) dut2 (
        .clk(clk), .rst(rst), .btn_step(b2_step), .btn_sel(b2_sel), .sw_run(b2_run),
        .cpu_clk(cpu_clk2), .led_mux_sel(led2), .step_count(step_count2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t pulse_q[$];
    exp_t led_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   exp_steps = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after a negedge, clear of the monitor's samples.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int at);
        exp_steps++;
        pulse_q.push_back('{at, exp_steps});
    endtask

    // Monitor
    logic       prev_clk  = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_led  = 4'd0;
    bit         in_pulse  = 1'b0;
    int         rise_cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            in_pulse = 1'b0;
        end else begin
            if (cpu_clk === 1'b1 && prev_clk === 1'b0) begin
                check("pulse_expected", int'(pulse_q.size() != 0), 1);
                if (pulse_q.size() != 0) begin
                    e = pulse_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_count", int'(step_count), e.val);
                end
                check("busy_at_rise", int'(busy), 1);
                in_pulse = 1'b1;
                rise_cyc = cyc;
            end
            if (cpu_clk === 1'b0 && prev_clk === 1'b1 && in_pulse) begin
                check("high_len", cyc - rise_cyc, PL);
            end
            if (busy === 1'b0 && prev_busy === 1'b1 && in_pulse) begin
                check("busy_len", cyc - rise_cyc, 2 * PL);
                in_pulse = 1'b0;
            end
            if (led_mux_sel !== prev_led) begin
                check("led_expected", int'(led_q.size() != 0), 1);
                if (led_q.size() != 0) begin
                    e = led_q.pop_front();
                    check("led_cycle", cyc, e.cyc);
                    check("led_value", int'(led_mux_sel), e.val);
                end
            end
        end
        prev_clk  = cpu_clk;
        prev_busy = busy;
        prev_led  = led_mux_sel;
    end

    int   rises2 = 0;
    logic prev2  = 1'b0;
    always @(negedge clk) begin
        if (rst && cpu_clk2 === 1'b1 && prev2 === 1'b0) rises2++;
        prev2 = cpu_clk2;
    end

    initial begin
        int c;
        int r;

        // Reset state
        tick(3);
        check("rst_cpu_clk", int'(cpu_clk), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_led", int'(led_mux_sel), 0);
        check("rst_steps", int'(step_count), 0);
        rst = 1'b1;
        tick(2);

        // Three-cycle glitch never reaches the debounce threshold
        btn_step = 1'b1;
        tick(3);
        btn_step = 1'b0;
        tick(20);
        check("glitch_steps", int'(step_count), 0);

        // Clean step press together with the first select press
        c = cyc;
        btn_step = 1'b1;
        btn_sel  = 1'b1;
        expect_pulse(c + 7);
        led_q.push_back('{c + 7, 1});
        tick(8);
        btn_step = 1'b0;
        btn_sel  = 1'b0;
        tick(8);

        // Remaining 16 select presses: 2..15, 0, 1
        for (int i = 2; i <= 17; i++) begin
            c = cyc;
            btn_sel = 1'b1;
            led_q.push_back('{c + 7, i % 16});
            tick(8);
            btn_sel = 1'b0;
            tick(8);
        end
        check("sel_steps", int'(step_count), 1);
        check("sel_final", int'(led_mux_sel), 1);

        // Run mode: debounced high at r, ticks every RP cycles, btn_step ignored
        c = cyc;
        sw_run = 1'b1;
        r = c + 6;
        for (int k = 1; k <= 5; k++) expect_pulse(r + RP * k);
        tick(15);
        btn_step = 1'b1;
        tick(8);
        btn_step = 1'b0;
        tick(10);
        btn_step = 1'b1;
        tick(8);
        btn_step = 1'b0;
        while (cyc < r + 49) tick(1);
        sw_run = 1'b0;
        tick(30);
        check("run_steps", int'(step_count), 6);

        // Second press debounces while dut2 is still in HIGH and is dropped
        b2_step = 1'b1;
        tick(4);
        b2_step = 1'b0;
        tick(4);
        b2_step = 1'b1;
        tick(30);
        check("drop_steps", int'(step_count2), 1);
        check("drop_pulses", rises2, 1);
        b2_step = 1'b0;
        tick(10);

        // Reset asserted while cpu_clk is high
        c = cyc;
        btn_step = 1'b1;
        expect_pulse(c + 7);
        tick(7);
        check("pre_reset_clk", int'(cpu_clk), 1);
        rst      = 1'b0;
        btn_step = 1'b0;
        tick(1);
        check("midrst_cpu_clk", int'(cpu_clk), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_steps", int'(step_count), 0);
        check("midrst_led", int'(led_mux_sel), 0);
        exp_steps = 0;
        tick(2);
        rst = 1'b1;
        tick(25);
        check("post_reset_steps", int'(step_count), 0);

        // Button already held when reset releases
        rst      = 1'b0;
        btn_step = 1'b1;
        tick(3);
        rst = 1'b1;
        c = cyc;
        expect_pulse(c + 7);
        tick(20);
        btn_step = 1'b0;
        tick(15);
        check("held_steps", int'(step_count), 1);

        check("pulse_q_empty", pulse_q.size(), 0);
        check("led_q_empty", led_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
